// File: rtl/hwgen_hdr_builder_pkg.sv
// Shared types and helpers for the hwgen header builder: input record header,
// logical hwgen header, output stream beat and the beat packing function.
package hwgen_hdr_builder_pkg;

    localparam logic [15:0] HWGEN_MAGIC_NUMBER_C  = 16'h6969;
    localparam int unsigned WIRE_OVERHEAD_BYTES_C = 20;
    localparam int unsigned NS_WIDTH_C            = 64;
    localparam int unsigned CYC_WIDTH_C           = 67;

    typedef struct packed {
        logic        valid;
        logic [63:0] ts;
        logic [31:0] incl_len;
        logic [31:0] orig_len;
    } genericrec_hdr_t;

    typedef struct packed {
        logic [31:0] ifg;
        logic [15:0] len;
        logic [15:0] magic;
    } hwgen_hdr_t;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic [7:0]  tstrb;
        logic        tlast;
    } hwgen_axis_t;

    typedef enum logic [1:0] {
        TS_FIRST,
        TS_FORWARD,
        TS_BACKWARD
    } ts_class_e;

    function automatic logic [63:0] hwgen_pack(input logic [15:0] magic,
                                               input logic [15:0] len,
                                               input logic [31:0] ifg);
        hwgen_hdr_t h;
        h.magic = magic;
        h.len   = len;
        h.ifg   = ifg;
        return h;
    endfunction

endpackage

// File: rtl/hwgen_hdr_builder_if.sv
// Header-in / hwgen-beat-out handshake bundle; the builder sits on the slave side.
interface hwgen_hdr_builder_if;
    import hwgen_hdr_builder_pkg::*;

    genericrec_hdr_t s_hdr;
    logic            s_hdr_ready;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [63:0]     m_axis_tdata;
    logic [7:0]      m_axis_tstrb;
    logic            m_axis_tlast;

    modport slave (
        input  s_hdr,
        input  m_axis_tready,
        output s_hdr_ready,
        output m_axis_tvalid,
        output m_axis_tdata,
        output m_axis_tstrb,
        output m_axis_tlast
    );

    modport master (
        output s_hdr,
        output m_axis_tready,
        input  s_hdr_ready,
        input  m_axis_tvalid,
        input  m_axis_tdata,
        input  m_axis_tstrb,
        input  m_axis_tlast
    );

endinterface

// File: rtl/hwgen_ns_to_cycles.sv
// Registered nanosecond-to-clock-cycle conversion: (ns * CYC_MUL) >> CYC_SHIFT, truncating.
module hwgen_ns_to_cycles
    import hwgen_hdr_builder_pkg::*;
#(
    parameter int unsigned CYC_MUL   = 5,
    parameter int unsigned CYC_SHIFT = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NS_WIDTH_C-1:0]  ns,
    output logic [CYC_WIDTH_C-1:0] cycles
);

    logic [CYC_WIDTH_C-1:0] product;

    assign product = CYC_WIDTH_C'(ns) * CYC_WIDTH_C'(CYC_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= '0;
        end else if (en) begin
            cycles <= product >> CYC_SHIFT;
        end
    end

endmodule

// File: rtl/hwgen_hdr_builder.sv
// Turns pcap record headers into one hwgen header beat each; the IFG is the timestamp
// delta in cycles minus the previous packet's wire time, clamped and saturated.
module hwgen_hdr_builder
    import hwgen_hdr_builder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CYC_MUL         = 5,
    parameter int unsigned CYC_SHIFT       = 5,
    parameter int unsigned BYTES_PER_CYCLE = 8,
    parameter int unsigned OVERHEAD_BYTES  = WIRE_OVERHEAD_BYTES_C,
    parameter int unsigned MIN_IFG_CYCLES  = 0
) (
    input  logic                clk,
    input  logic                rst,
    hwgen_hdr_builder_if.slave  bus,
    output logic [31:0]         pkt_count,
    output logic [31:0]         ts_back_count,
    output logic                len_sat_err
);

    localparam logic signed [67:0] IFG_MAX_C = 68'sh0_FFFF_FFFF;

    genericrec_hdr_t hdr;
    logic            en;
    logic            unused_incl_len;

    logic            prev_valid;
    logic [63:0]     prev_ts;
    logic [31:0]     prev_orig_len;

    ts_class_e       ts_class;
    logic [32:0]     wire_prev;

    logic            s1_valid;
    logic            s1_first;
    logic [63:0]     s1_delta;
    logic [32:0]     s1_wire;
    logic [15:0]     s1_len;

    logic                   s2_valid;
    logic                   s2_first;
    logic [32:0]            s2_wire;
    logic [15:0]            s2_len;
    logic [CYC_WIDTH_C-1:0] s2_dcyc;

    logic signed [67:0] gap;
    logic signed [67:0] min_gap;
    logic [31:0]        ifg;
    hwgen_axis_t        beat;

    assign hdr             = bus.s_hdr;
    assign unused_incl_len = ^hdr.incl_len;
    assign en              = !s2_valid || bus.m_axis_tready;
    assign bus.s_hdr_ready = en;

    always_comb begin
        ts_class = TS_FORWARD;
        if (!prev_valid) begin
            ts_class = TS_FIRST;
        end else if (hdr.ts < prev_ts) begin
            ts_class = TS_BACKWARD;
        end
    end

    // ceil((len + overhead) / bytes_per_cycle) of the packet before this one
    assign wire_prev = (33'(prev_orig_len) + 33'(OVERHEAD_BYTES + BYTES_PER_CYCLE - 1))
                       / 33'(BYTES_PER_CYCLE);

    // S1: timestamp delta, previous wire time, length saturation, history update
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_first      <= 1'b0;
            s1_delta      <= '0;
            s1_wire       <= '0;
            s1_len        <= '0;
            prev_valid    <= 1'b0;
            prev_ts       <= '0;
            prev_orig_len <= '0;
            ts_back_count <= '0;
            len_sat_err   <= 1'b0;
        end else if (en) begin
            s1_valid <= hdr.valid;
            if (hdr.valid) begin
                s1_first      <= (ts_class == TS_FIRST);
                s1_delta      <= (ts_class == TS_FORWARD) ? hdr.ts - prev_ts : '0;
                s1_wire       <= wire_prev;
                s1_len        <= (hdr.orig_len > 32'h0000_FFFF) ? 16'hFFFF : hdr.orig_len[15:0];
                prev_valid    <= 1'b1;
                prev_ts       <= hdr.ts;
                prev_orig_len <= hdr.orig_len;
                if (hdr.orig_len > 32'h0000_FFFF) begin
                    len_sat_err <= 1'b1;
                end
                if (ts_class == TS_BACKWARD && ts_back_count != '1) begin
                    ts_back_count <= ts_back_count + 32'd1;
                end
            end
        end
    end

    hwgen_ns_to_cycles #(
        .CYC_MUL   (CYC_MUL),
        .CYC_SHIFT (CYC_SHIFT)
    ) u_ns_to_cycles (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ns     (s1_delta),
        .cycles (s2_dcyc)
    );

    // S2: holds alongside the converted delta; doubles as the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_wire   <= '0;
            s2_len    <= '0;
            pkt_count <= '0;
        end else begin
            if (en) begin
                s2_valid <= s1_valid;
                s2_first <= s1_first;
                s2_wire  <= s1_wire;
                s2_len   <= s1_len;
            end
            if (s2_valid && bus.m_axis_tready) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

    assign min_gap = $signed(68'(MIN_IFG_CYCLES));

    always_comb begin
        gap = $signed({1'b0, s2_dcyc}) - $signed({35'd0, s2_wire});
        if (s2_first || gap < min_gap) begin
            ifg = 32'(MIN_IFG_CYCLES);
        end else if (gap > IFG_MAX_C) begin
            ifg = '1;
        end else begin
            ifg = gap[31:0];
        end
    end

    always_comb begin
        beat = '0;
        if (s2_valid) begin
            beat.tvalid = 1'b1;
            beat.tdata  = hwgen_pack(HWGEN_MAGIC_NUMBER_C, s2_len, ifg);
            beat.tstrb  = '1;
            beat.tlast  = 1'b1;
        end
    end

    assign bus.m_axis_tvalid = beat.tvalid;
    assign bus.m_axis_tdata  = beat.tdata[DATA_WIDTH-1:0];
    assign bus.m_axis_tstrb  = beat.tstrb;
    assign bus.m_axis_tlast  = beat.tlast;

endmodule
